// File: rtl/noc_request_axilite.sv
// noc_request_axilite: accepts AXI-lite write (AW+W) and read (AR) requests and
// turns each into an OpenPiton-style non-cacheable NoC request packet
// (three header flits, plus data flits for stores).
//
// Handshakes: a transfer on any channel happens on a rising clk edge where
// valid and ready are both high; ready never depends combinationally on valid.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_DST_CHIPID
`define MSG_DST_CHIPID 63:50
`define MSG_DST_X 49:42
`define MSG_DST_Y 41:34
`define MSG_LENGTH 29:22
`define MSG_TYPE 21:14
`define MSG_MSHRID 13:6
`define MSG_ADDR 63:16
`define MSG_ADDR_WIDTH 48
`define MSG_DATA_SIZE 10:8
`define MSG_DATA_SIZE_WIDTH 3
`define MSG_SRC_CHIPID 63:50
`define MSG_SRC_X 49:42
`define MSG_SRC_Y 41:34
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`define MSG_DATA_SIZE_8B 3'b100
`endif

module noc_request_axilite #(
  parameter int AXI_LITE_DATA_WIDTH = 64,
  parameter int AXI_LITE_ADDR_WIDTH = 64,
  parameter int DEST_CHIPID = 0,
  parameter int DEST_X = 0,
  parameter int DEST_Y = 0,
  parameter int SRC_CHIPID = 0,
  parameter int SRC_X = 0,
  parameter int SRC_Y = 0,
  parameter logic [`MSG_DATA_SIZE_WIDTH-1:0] DATA_SIZE = `MSG_DATA_SIZE_8B
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [AXI_LITE_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_LITE_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic                             noc_valid_out,
  output logic [`NOC_DATA_WIDTH-1:0]       noc_data_out,
  input  logic                             noc_ready_in,
  output logic [2:0]                       dbg_state
);

  localparam int NW     = `NOC_DATA_WIDTH;
  localparam int NBEATS = AXI_LITE_DATA_WIDTH / NW;
  localparam int SW     = AXI_LITE_DATA_WIDTH / 8;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;

  state_t state, state_d;

  logic                           init_done;
  logic                           aw_full, w_full, ar_full;
  logic [AXI_LITE_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [AXI_LITE_DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0]                  w_strb_q;

  logic                           last_load;
  logic                           pkt_store;
  logic [AXI_LITE_ADDR_WIDTH-1:0] pkt_addr;
  logic [AXI_LITE_DATA_WIDTH-1:0] pkt_data;
  logic [SW-1:0]                  pkt_strb;
  logic [7:0]                     tag;
  logic [BW-1:0]                  beat;

  logic store_pend, load_pend, grant, grant_store, fire, last_flit;
  logic [NW-1:0] addr_ext, hdr0, hdr1, hdr2;
  logic unused_addr_hi;

  assign s_axi_awready = init_done & ~aw_full;
  assign s_axi_wready  = init_done & ~w_full;
  assign s_axi_arready = init_done & ~ar_full;

  assign store_pend  = aw_full & w_full;
  assign load_pend   = ar_full;
  assign grant       = (state == IDLE) & (store_pend | load_pend);
  // Store wins only if no load is waiting or the previous grant went to a load.
  assign grant_store = store_pend & (~load_pend | last_load);

  assign noc_valid_out = (state != IDLE);
  assign fire          = noc_valid_out & noc_ready_in;
  assign last_flit     = fire & (((state == HDR2) & ~pkt_store) |
                                 ((state == DATA) & (beat == BW'(NBEATS - 1))));
  assign dbg_state     = state;

  // Readies stay low through reset and rise on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // Single-entry channel buffers; a buffer freed this cycle had ready low, so it
  // cannot be refilled on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (last_flit && pkt_store) aw_full <= 1'b0;
      else if (s_axi_awvalid && s_axi_awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (last_flit && pkt_store) w_full <= 1'b0;
      else if (s_axi_wvalid && s_axi_wready) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (last_flit && !pkt_store) ar_full <= 1'b0;
      else if (s_axi_arvalid && s_axi_arready) begin
        ar_full   <= 1'b1;
        ar_addr_q <= s_axi_araddr;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // FSM next-state: each flit advances only when accepted.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (store_pend || load_pend) state_d = HDR0;
      HDR0:    if (fire) state_d = HDR1;
      HDR1:    if (fire) state_d = HDR2;
      HDR2:    if (fire) state_d = pkt_store ? DATA : IDLE;
      DATA:    if (last_flit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Packet registers: capture the granted request, track data beats and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_load <= 1'b0;
      pkt_store <= 1'b0;
      pkt_addr  <= '0;
      pkt_data  <= '0;
      pkt_strb  <= '0;
      tag       <= 8'd0;
      beat      <= '0;
    end else begin
      if (grant) begin
        last_load <= ~grant_store;
        pkt_store <= grant_store;
        pkt_addr  <= grant_store ? aw_addr_q : ar_addr_q;
        pkt_data  <= w_data_q;
        pkt_strb  <= w_strb_q;
        beat      <= '0;
      end else if (fire && (state == DATA) && !last_flit) begin
        beat <= beat + 1'b1;
      end
      if (last_flit) tag <= tag + 8'd1;
    end
  end

  // Flit formatting and output mux; zero while idle.
  always_comb begin
    addr_ext = NW'(pkt_addr);
    hdr0 = '0;
    hdr0[`MSG_DST_CHIPID] = 14'(DEST_CHIPID);
    hdr0[`MSG_DST_X]      = 8'(DEST_X);
    hdr0[`MSG_DST_Y]      = 8'(DEST_Y);
    hdr0[`MSG_LENGTH]     = pkt_store ? 8'(2 + NBEATS) : 8'd2;
    hdr0[`MSG_TYPE]       = pkt_store ? `MSG_TYPE_NC_STORE_REQ : `MSG_TYPE_NC_LOAD_REQ;
    hdr0[`MSG_MSHRID]     = tag;
    hdr1 = '0;
    hdr1[`MSG_ADDR]       = addr_ext[`MSG_ADDR_WIDTH-1:0];
    hdr1[`MSG_DATA_SIZE]  = DATA_SIZE;
    hdr2 = '0;
    hdr2[SW-1:0]          = pkt_store ? pkt_strb : '0;
    hdr2[`MSG_SRC_CHIPID] = 14'(SRC_CHIPID);
    hdr2[`MSG_SRC_X]      = 8'(SRC_X);
    hdr2[`MSG_SRC_Y]      = 8'(SRC_Y);
    case (state)
      HDR0:    noc_data_out = hdr0;
      HDR1:    noc_data_out = hdr1;
      HDR2:    noc_data_out = hdr2;
      DATA:    noc_data_out = pkt_data[int'(beat) * NW +: NW];
      default: noc_data_out = '0;
    endcase
  end

  assign unused_addr_hi = ^addr_ext[NW-1:`MSG_ADDR_WIDTH];

endmodule

// File: tb/tb_noc_request_axilite.sv
// Directed bench for noc_request_axilite: expected flits are queued when a
// request is driven and compared as the NoC side accepts them.
module tb_noc_request_axilite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_arvalid, s_axi_arready;
  logic        noc_valid_out, noc_ready_in;
  logic [63:0] noc_data_out;
  logic [2:0]  dbg_state;

  logic [63:0] exp_q[$];
  logic [7:0]  tag_m;
  int check_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  noc_request_axilite #(
    .AXI_LITE_DATA_WIDTH(64), .AXI_LITE_ADDR_WIDTH(64),
    .DEST_CHIPID(5), .DEST_X(2), .DEST_Y(1),
    .SRC_CHIPID(7), .SRC_X(4), .SRC_Y(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .noc_valid_out(noc_valid_out), .noc_data_out(noc_data_out), .noc_ready_in(noc_ready_in),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected flit formats, written from the field layout.
  function automatic logic [63:0] h0(input logic [7:0] typ, input logic [7:0] len,
                                     input logic [7:0] mshr);
    return {14'd5, 8'd2, 8'd1, 4'd0, len, typ, mshr, 6'd0};
  endfunction

  function automatic logic [63:0] h1(input logic [63:0] addr);
    return {addr[47:0], 5'd0, 3'b100, 8'd0};
  endfunction

  function automatic logic [63:0] h2(input logic [7:0] strb);
    return {14'd7, 8'd4, 8'd6, 4'd0, 22'd0, strb};
  endfunction

  task automatic push_load(input logic [63:0] addr);
    exp_q.push_back(h0(8'd14, 8'd2, tag_m));
    exp_q.push_back(h1(addr));
    exp_q.push_back(h2(8'h00));
    tag_m++;
  endtask

  task automatic push_store(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb);
    exp_q.push_back(h0(8'd15, 8'd3, tag_m));
    exp_q.push_back(h1(addr));
    exp_q.push_back(h2(strb));
    exp_q.push_back(data);
    tag_m++;
  endtask

  // NoC-side monitor: pop on acceptance, hold-check on stall.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && noc_valid_out === 1'b1) begin
      if (exp_q.size() == 0)
        check("spurious_valid", {63'd0, noc_valid_out}, 64'd0);
      else if (noc_ready_in === 1'b1)
        check("flit", noc_data_out, exp_q.pop_front());
      else
        check("stall_hold", noc_data_out, exp_q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: raise the requested valids, drop each once its handshake edge passes.
  task automatic axi_send(input bit do_aw, input bit do_w, input bit do_ar,
                          input logic [63:0] aw_a, input logic [63:0] ar_a,
                          input logic [63:0] data, input logic [7:0] strb);
    bit aw_p, w_p, ar_p, hs_aw, hs_w, hs_ar;
    int n;
    aw_p = do_aw; w_p = do_w; ar_p = do_ar; n = 0;
    s_axi_awaddr = aw_a; s_axi_araddr = ar_a;
    s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = aw_p; s_axi_wvalid = w_p; s_axi_arvalid = ar_p;
    while ((aw_p || w_p || ar_p) && n < 200) begin
      @(negedge clk);
      hs_aw = aw_p && s_axi_awready;
      hs_w  = w_p && s_axi_wready;
      hs_ar = ar_p && s_axi_arready;
      step();
      if (hs_aw) begin aw_p = 0; s_axi_awvalid = 1'b0; end
      if (hs_w)  begin w_p = 0;  s_axi_wvalid = 1'b0;  end
      if (hs_ar) begin ar_p = 0; s_axi_arvalid = 1'b0; end
      n++;
    end
    if (aw_p || w_p || ar_p) begin
      check("hs_timeout", {61'd0, aw_p, w_p, ar_p}, 64'd0);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    step();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (noc_valid_out !== 1'b1 && n < 20);
    check(tag, {63'd0, noc_valid_out}, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tag_m = 8'd0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [63:0] a, d;
    logic [7:0]  s;
    rst_n = 1'b0;
    noc_ready_in = 1'b0;
    tag_m = 8'd0;
    s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    check("rst_readies", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
    check("rst_valid", {63'd0, noc_valid_out}, 64'd0);
    check("rst_data", noc_data_out, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("readies_before_edge", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
    @(negedge clk);
    check("readies_after_edge", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd7);
    step();
    noc_ready_in = 1'b1;

    // Single load, full throughput
    push_load(64'h1000_0040);
    axi_send(0, 0, 1, 64'd0, 64'h1000_0040, 64'd0, 8'd0);
    @(negedge clk);
    check("load_pending_gap", {63'd0, noc_valid_out}, 64'd0);
    @(negedge clk);
    check("load_valid_rise", {63'd0, noc_valid_out}, 64'd1);
    repeat (3) step();
    check("load_consecutive", 64'(exp_q.size()), 64'd0);
    check("load_back_idle", {63'd0, noc_valid_out}, 64'd0);

    // Store with W three cycles after AW
    axi_send(1, 0, 0, 64'h2000_0008, 64'd0, 64'd0, 8'd0);
    repeat (3) begin
      @(negedge clk);
      check("store_wait_w", {63'd0, noc_valid_out}, 64'd0);
    end
    step();
    push_store(64'h2000_0008, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    axi_send(0, 1, 0, 64'd0, 64'd0, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    @(negedge clk);
    check("store_pending_gap", {63'd0, noc_valid_out}, 64'd0);
    @(negedge clk);
    check("store_valid_rise", {63'd0, noc_valid_out}, 64'd1);
    wait_drain("store_drain", 20);

    // Backpressure in HDR1 with a second load waiting
    push_load(64'h3000_0100);
    axi_send(0, 0, 1, 64'd0, 64'h3000_0100, 64'd0, 8'd0);
    wait_valid("bp_valid");
    step();
    noc_ready_in = 1'b0;
    push_load(64'h3000_0200);
    s_axi_araddr = 64'h3000_0200;
    s_axi_arvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_arready_low", {63'd0, s_axi_arready}, 64'd0);
      check("bp_valid_held", {63'd0, noc_valid_out}, 64'd1);
    end
    step();
    noc_ready_in = 1'b1;
    axi_send(0, 0, 1, 64'd0, 64'h3000_0200, 64'd0, 8'd0);
    wait_drain("bp_drain", 40);

    // Tag wrap: 257 loads from reset, the last one wraps to mshrid 0
    do_reset();
    for (int i = 0; i < 257; i++) begin
      a = {32'd0, $urandom_range(32'hFFFF_FFF0, 0)};
      push_load(a);
      axi_send(0, 0, 1, 64'd0, a, 64'd0, 8'd0);
    end
    wait_drain("wrap_drain", 40);

    // Reset while a store is in its data flit
    d = {$urandom, $urandom};
    s = 8'($urandom_range(255, 1));
    push_store(64'h4000_0010, d, s);
    axi_send(1, 1, 0, 64'h4000_0010, 64'd0, d, s);
    wait_valid("mid_valid");
    repeat (3) step();
    noc_ready_in = 1'b0;
    @(negedge clk);
    check("mid_in_data", {63'd0, noc_valid_out}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, noc_valid_out}, 64'd0);
    check("mid_rst_data", noc_data_out, 64'd0);
    check("mid_rst_readies", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
    exp_q.delete();
    tag_m = 8'd0;
    step();
    step();
    rst_n = 1'b1;
    noc_ready_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_resend", {63'd0, noc_valid_out}, 64'd0);
    end
    step();
    push_load(64'h5000_0000);
    axi_send(0, 0, 1, 64'd0, 64'h5000_0000, 64'd0, 8'd0);
    wait_drain("post_rst_load", 20);

    // Contention twice from reset: load, store, load, store
    do_reset();
    noc_ready_in = 1'b1;
    for (int r = 0; r < 2; r++) begin
      a = {32'd0, $urandom};
      d = {$urandom, $urandom};
      s = 8'($urandom_range(255, 0));
      push_load(a);
      push_store(64'h6000_0080, d, s);
      axi_send(1, 1, 1, 64'h6000_0080, a, d, s);
      wait_drain("contention_drain", 40);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
